// File: rtl/clz_normalise_pkg.sv
// ----------------------------------------------------------------------------
// clz_normalise_pkg
//   Shared helpers for the normaliser slice.
//   clog2() sizes the leading-zero count and exponent fields so the top and
//   the count unit agree on widths from one definition.
// ----------------------------------------------------------------------------
package clz_normalise_pkg;

    // Ceiling log2 for elaboration-time width sizing (v >= 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/clz_normalise_clz.sv
// ----------------------------------------------------------------------------
// clz_normalise_clz
//   Leading-zero counter for a bits_in-wide word (bits_in a power of two).
//   Ports:
//     in    [bits_in-1:0]   word to scan
//     out   [OUT_W-1:0]     number of zeros above the highest set bit
//     valid                 1 when any bit of in is set; 0 means all-zero
//                           (out is 0 in that case and must be ignored)
// ----------------------------------------------------------------------------
module clz_normalise_clz
    import clz_normalise_pkg::*;
#(
    parameter int bits_in = 16,
    localparam int OUT_W  = clog2(bits_in)
) (
    input  logic [bits_in-1:0] in,
    output logic [OUT_W-1:0]   out,
    output logic               valid
);

    logic [OUT_W-1:0] cnt;
    logic             any;

    // Scan LSB to MSB; the last hit is the highest set bit, so it wins.
    always_comb begin
        cnt = '0;
        any = 1'b0;
        for (int i = 0; i < bits_in; i++) begin
            if (in[i]) begin
                cnt = OUT_W'(bits_in - 1 - i);
                any = 1'b1;
            end
        end
    end

    assign out   = cnt;
    assign valid = any;

endmodule

// File: rtl/clz_normalise.sv
// ----------------------------------------------------------------------------
// clz_normalise
//   Two-stage pipelined integer normaliser with valid/ready on both sides.
//   Stage 1: sign/magnitude conversion and leading-zero count.
//   Stage 2: left-shift magnitude so its MSB is 1, emit MSB-position exponent.
//   Ports:
//     clk, rst                 clock (rising) / async active-high reset
//     in_valid/in_ready        upstream handshake
//     in_data   [WIDTH-1:0]    integer to normalise (two's complement if SIGNED)
//     out_valid/out_ready      downstream handshake
//     out_sign                 input was negative (only when SIGNED)
//     out_zero                 input was zero
//     out_exp   [EXP_W-1:0]    bit index of magnitude MSB
//     out_mant  [WIDTH-1:0]    normalised magnitude (MSB set unless zero)
//   All out_* come straight from stage-2 registers.
// ----------------------------------------------------------------------------
module clz_normalise
    import clz_normalise_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b0,
    localparam int EXP_W = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic             out_zero,
    output logic [EXP_W-1:0] out_exp,
    output logic [WIDTH-1:0] out_mant
);

    // ---------------- stage 1 combinational front end ----------------
    logic             neg;
    logic [WIDTH-1:0] mag;
    logic [EXP_W-1:0] lzc_c;
    logic             nz_c;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly the
    // correct magnitude, so no overflow handling is needed.
    assign neg = SIGNED && in_data[WIDTH-1];
    assign mag = neg ? (~in_data + 1'b1) : in_data;

    clz_normalise_clz #(.bits_in(WIDTH)) u_clz (
        .in    (mag),
        .out   (lzc_c),
        .valid (nz_c)
    );

    // ---------------- handshake / load enables ----------------
    logic             s1_valid, s2_valid;
    logic             s1_load,  s2_load;
    logic [WIDTH-1:0] s1_mag;
    logic [EXP_W-1:0] s1_lzc;
    logic             s1_sign, s1_zero;

    // Stage 2 drains into the consumer or refills when the consumer takes
    // its word, giving full throughput; out_ready reaches in_ready
    // combinationally through s2_load.
    assign s2_load  = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    assign out_valid = s2_valid;

    // ---------------- stage 1 register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mag   <= '0;
            s1_lzc   <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_mag   <= mag;
                s1_lzc   <= lzc_c;
                s1_sign  <= neg;
                s1_zero  <= !nz_c;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- stage 2 register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_sign <= 1'b0;
            out_zero <= 1'b0;
            out_exp  <= '0;
            out_mant <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                out_zero <= s1_zero;
                if (s1_zero) begin
                    out_sign <= 1'b0;
                    out_exp  <= '0;
                    out_mant <= '0;
                end else begin
                    out_sign <= s1_sign;
                    out_exp  <= EXP_W'(WIDTH - 1) - s1_lzc;
                    out_mant <= s1_mag << s1_lzc;
                end
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule
